// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: mode codes, lamp-test states, hex font.
// Pure definitions; no timing or flow control involved.
package seg_pkg;

    localparam logic [1:0] MODE_HEX   = 2'b00;
    localparam logic [1:0] MODE_BLANK = 2'b01;
    localparam logic [1:0] MODE_TEST  = 2'b10;

    // Walk states carry the lit segment index in their low 3 bits (7 = dp).
    typedef enum logic [3:0] {
        T_S0  = 4'd0,
        T_S1  = 4'd1,
        T_S2  = 4'd2,
        T_S3  = 4'd3,
        T_S4  = 4'd4,
        T_S5  = 4'd5,
        T_S6  = 4'd6,
        T_S7  = 4'd7,
        T_ALL = 4'd8
    } test_state_t;

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex nibble to active-high {A..G} segment pattern.
// Combinational, zero latency; no flow control.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed common-anode 7-segment scanner with prescaler, frame-coherent shadow capture and lamp test.
// Outputs registered (one cycle after the scan state); free-running, no backpressure.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int DIV       = 50000,
    parameter int TEST_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [1:0]              mode,
    input  logic                    lz_en,
    output logic [N_DIGITS-1:0]     anodes_n,
    output logic [6:0]              segments_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int CNT_W  = $clog2(DIV);
    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int HOLD_W = $clog2(TEST_HOLD + 1);

    logic [CNT_W-1:0]                cnt;
    logic [IDX_W-1:0]                idx;
    logic                            tick;
    logic                            last_digit;
    logic                            boundary;

    logic [N_DIGITS-1:0][3:0]        sh_data;
    logic [N_DIGITS-1:0]             sh_dp;
    logic [1:0]                      sh_mode;
    logic                            sh_lz;

    test_state_t                     state, state_nxt;
    logic [HOLD_W-1:0]               hold_cnt, hold_nxt;
    logic [6:0]                      test_seg;
    logic                            test_dp;

    logic [6:0]                      hex_seg;
    logic [N_DIGITS-1:0]             lz_blank;
    logic                            all_zero;
    logic [6:0]                      seg_on;
    logic                            dp_on;

    assign tick       = (cnt == CNT_W'(DIV - 1));
    assign last_digit = (idx == IDX_W'(N_DIGITS - 1));
    assign boundary   = tick && last_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= last_digit ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_mode    <= MODE_HEX;
            sh_lz      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (boundary) begin
                sh_data <= data;
                sh_dp   <= dp;
                sh_mode <= mode;
                sh_lz   <= lz_en;
            end
        end
    end

    // Lamp-test FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= T_ALL;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Lamp-test FSM: next state, decided on the mode of the frame that is ending
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        if (boundary) begin
            if (sh_mode != MODE_TEST) begin
                state_nxt = T_ALL;
                hold_nxt  = '0;
            end else if (hold_cnt == HOLD_W'(TEST_HOLD - 1)) begin
                hold_nxt = '0;
                case (state)
                    T_ALL:   state_nxt = T_S0;
                    T_S7:    state_nxt = T_ALL;
                    default: state_nxt = test_state_t'(state + 4'd1);
                endcase
            end else begin
                hold_nxt = hold_cnt + 1'b1;
            end
        end
    end

    // Lamp-test FSM: pattern output
    always_comb begin
        test_seg = 7'h00;
        test_dp  = 1'b0;
        if (state == T_ALL) begin
            test_seg = 7'h7F;
            test_dp  = 1'b1;
        end else if (state[2:0] == 3'd7) begin
            test_dp  = 1'b1;
        end else begin
            test_seg = 7'b1000000 >> state[2:0];
        end
    end

    seg_hex_decoder u_hex_decoder (
        .nibble (sh_data[idx]),
        .seg    (hex_seg)
    );

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            all_zero    = all_zero && (sh_data[k] == 4'd0);
            lz_blank[k] = all_zero;
        end
    end

    always_comb begin
        seg_on = 7'h00;
        dp_on  = 1'b0;
        case (sh_mode)
            MODE_HEX: begin
                seg_on = (sh_lz && lz_blank[idx]) ? 7'h00 : hex_seg;
                dp_on  = sh_dp[idx];
            end
            MODE_TEST: begin
                seg_on = test_seg;
                dp_on  = test_dp;
            end
            default: begin
                seg_on = 7'h00;
                dp_on  = 1'b0;
            end
        endcase
    end

    // The cycle after each tick is an all-off gap to avoid ghosting between digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes_n   <= '1;
            segments_n <= '1;
            dp_n       <= 1'b1;
        end else if (tick) begin
            anodes_n   <= '1;
            segments_n <= '1;
            dp_n       <= 1'b1;
        end else begin
            anodes_n   <= ~(N_DIGITS'(1) << idx);
            segments_n <= ~seg_on;
            dp_n       <= ~dp_on;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench: every frame's expected digit slots are queued when its inputs are driven.
module tb_seg_display_scan;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int HOLD  = 1;
    localparam int FRAME = N * DIV;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  data;
    logic [3:0]   dp;
    logic [1:0]   mode;
    logic         lz_en;
    logic [3:0]   anodes_n;
    logic [6:0]   segments_n;
    logic         dp_n;
    logic         frame_done;

    seg_display_scan #(.N_DIGITS(N), .DIV(DIV), .TEST_HOLD(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .dp         (dp),
        .mode       (mode),
        .lz_en      (lz_en),
        .anodes_n   (anodes_n),
        .segments_n (segments_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
    } slot_t;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  p;
        logic [1:0]  m;
        logic        lz;
    } stim_t;

    int      n_tests = 0;
    int      n_fail  = 0;
    slot_t   sb[$];
    stim_t   stims[$];
    bit      mon_en  = 1'b0;
    int      tstep   = -1;
    logic [1:0] prev_mode = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] font(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return t[h];
    endfunction

    // Queue the four slots of the frame that will display these inputs.
    task automatic push_frame(input stim_t s);
        slot_t      e [N];
        logic [6:0] seg;
        logic       dpo;
        logic       nz;
        logic [3:0] nib;
        if (s.m == 2'b10)
            tstep = (prev_mode == 2'b10) ? ((tstep == 7) ? -1 : tstep + 1) : -1;
        prev_mode = s.m;
        nz = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            nib = s.d[4*k +: 4];
            nz  = nz | (nib != 4'd0);
            seg = 7'h00;
            dpo = 1'b0;
            if (s.m == 2'b00) begin
                seg = (s.lz && !nz && k != 0) ? 7'h00 : font(nib);
                dpo = s.p[k];
            end else if (s.m == 2'b10) begin
                if (tstep == -1) begin
                    seg = 7'h7F; dpo = 1'b1;
                end else if (tstep == 7) begin
                    dpo = 1'b1;
                end else begin
                    seg = 7'h40 >> tstep;
                end
            end
            e[k].an  = ~(4'b0001 << k);
            e[k].seg = ~seg;
            e[k].dpn = ~dpo;
        end
        for (int k = 0; k < N; k++) sb.push_back(e[k]);
    endtask

    task automatic add(input logic [15:0] d, input logic [3:0] p, input logic [1:0] m, input logic lz);
        stim_t s;
        s.d = d; s.p = p; s.m = m; s.lz = lz;
        stims.push_back(s);
    endtask

    task automatic apply(input stim_t s);
        data = s.d; dp = s.p; mode = s.m; lz_en = s.lz;
    endtask

    task automatic wait_fd();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!frame_done && c < 4 * FRAME);
        if (!frame_done) chk("fd_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pop one expected slot at the start of each lit-anode run.
    logic [3:0] prev_an = 4'hF;
    int         run = 0;
    int         fd_gap = 0;
    bit         fd_seen = 1'b0;
    slot_t      cur = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (anodes_n != 4'hF) begin
                if (prev_an == 4'hF) begin
                    if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                    else cur = sb.pop_front();
                    run = 0;
                end
                run++;
                chk("slot_an", {28'd0, anodes_n}, {28'd0, cur.an});
                chk("slot_seg", {25'd0, segments_n}, {25'd0, cur.seg});
                chk("slot_dp", {31'd0, dp_n}, {31'd0, cur.dpn});
            end else if (prev_an != 4'hF) begin
                chk("slot_len", run, DIV - 1);
            end
            prev_an = anodes_n;
            fd_gap++;
            if (frame_done) begin
                if (fd_seen) chk("fd_period", fd_gap, FRAME);
                fd_seen = 1'b1;
                fd_gap  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int    fd_at;
        stim_t zero;

        add(16'h1234, 4'b0000, 2'b00, 1'b0);
        add(16'h1234, 4'b0101, 2'b00, 1'b0);
        add(16'h0050, 4'b0000, 2'b00, 1'b1);
        add(16'h0050, 4'b1000, 2'b00, 1'b1);
        add(16'h0000, 4'b0000, 2'b00, 1'b1);
        add(16'hFFFF, 4'b0000, 2'b00, 1'b0);
        add(16'hABCD, 4'b1111, 2'b01, 1'b0);
        add(16'hABCD, 4'b1111, 2'b11, 1'b0);
        for (int i = 0; i < 11; i++) add(16'h5A5A, 4'b1111, 2'b10, 1'b0);
        add(16'h89EF, 4'b0011, 2'b00, 1'b1);
        add(16'h0000, 4'b0000, 2'b10, 1'b0);
        add(16'h0007, 4'b0000, 2'b00, 1'b1);
        add(16'h0000, 4'b0000, 2'b10, 1'b0);
        add(16'h0000, 4'b0000, 2'b10, 1'b0);
        add(16'h0000, 4'b0000, 2'b01, 1'b0);

        rst_n = 1'b0;
        apply(stims[0]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_an", {28'd0, anodes_n}, 32'hF);
            chk("rst_seg", {25'd0, segments_n}, 32'h7F);
            chk("rst_dp", {31'd0, dp_n}, 32'd1);
            chk("rst_fd", {31'd0, frame_done}, 32'd0);
        end

        zero = '0;
        push_frame(zero);
        push_frame(stims[0]);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 1; i < stims.size(); i++) begin
            wait_fd();
            repeat (7) @(negedge clk);
            apply(stims[i]);
            push_frame(stims[i]);
        end
        wait_fd();
        wait_fd();
        #1;
        mon_en = 1'b0;
        chk("sb_empty", sb.size(), 32'd0);

        // Asynchronous reset in the middle of digit 2's slot.
        fd_at = 0;
        for (int c = 0; c < 2 * FRAME && anodes_n != 4'b1011; c++) @(negedge clk);
        chk("rst6_pre_an", {28'd0, anodes_n}, 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst6_an", {28'd0, anodes_n}, 32'hF);
        chk("rst6_seg", {25'd0, segments_n}, 32'h7F);
        chk("rst6_dp", {31'd0, dp_n}, 32'd1);
        chk("rst6_fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4 * FRAME; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("rst6_d0_an", {28'd0, anodes_n}, 32'hE);
                chk("rst6_d0_seg", {25'd0, segments_n}, 32'h01);
            end
            if (c == 3) chk("rst6_d0_hold", {28'd0, anodes_n}, 32'hE);
            if (c == 4) chk("rst6_gap", {28'd0, anodes_n}, 32'hF);
            if (c == 5) chk("rst6_d1_an", {28'd0, anodes_n}, 32'hD);
            if (frame_done) begin
                fd_at = c;
                break;
            end
        end
        chk("rst6_fd_lat", fd_at, FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
